// File: rtl/shift_proc_pkg.sv
// Shared definitions for the shift processing unit.
// Holds the operation encoding, the control FSM state type and a helper that
// tells whether an operation consumes the shift amount.
package shift_proc_pkg;

    typedef enum logic [2:0] {
        OpPass  = 3'b000,
        OpCompl = 3'b001,
        OpLsr   = 3'b010,
        OpLsl   = 3'b011,
        OpRor   = 3'b100,
        OpRol   = 3'b101,
        OpAsr   = 3'b110,
        OpRsvd  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Pass, complement and the reserved code finish without stepping.
    function automatic logic is_shift_op(input op_e op);
        return !(op inside {OpPass, OpCompl, OpRsvd});
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-position move of the accumulator according to the captured operation.
// The MSB is the leftmost bit, so "left" moves data toward the MSB.
// Ports:
//   op    - operation code (shift_proc_pkg::op_e encoding)
//   din   - current accumulator value
//   dout  - accumulator value after a single step
module shift_step
    import shift_proc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op_e'(op))
            OpLsr:   dout = {1'b0, din[WIDTH-1:1]};
            OpLsl:   dout = {din[WIDTH-2:0], 1'b0};
            OpRor:   dout = {din[0], din[WIDTH-1:1]};
            OpRol:   dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OpAsr:   dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_proc_unit.sv
// Small register file plus a bit-serial shift/rotate engine.
// A start in IDLE copies reg[rd_sel] into an accumulator, steps it one bit per
// cycle for sh cycles, then writes it to reg[dst_sel] and to result.
// Ports:
//   clk, reset       - clock, synchronous active-low reset
//   load, fb, in     - register write request, source select, external data
//   wr_sel           - register written by load
//   rd_sel           - read port / operation source register
//   dst_sel, op, sh  - writeback register, operation, shift amount (at start)
//   start            - begin an operation (ignored while busy)
//   busy, done       - operation in progress, one-cycle completion pulse
//   result, rd_data  - last completed result, combinational read of reg[rd_sel]
module shift_proc_unit
    import shift_proc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    localparam int unsigned SHW  = $clog2(WIDTH),
    localparam int unsigned RSW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             fb,
    input  logic [WIDTH-1:0] in,
    input  logic [RSW-1:0]   wr_sel,
    input  logic [RSW-1:0]   rd_sel,
    input  logic [RSW-1:0]   dst_sel,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   sh,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [SHW-1:0] CntOne = {{(SHW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [RSW-1:0]   dst_q, dst_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] step_out;
    logic             ld_en;
    logic             wb_en;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .op   (op_q),
        .din  (acc_q),
        .dout (step_out)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dst_d    = dst_q;
        result_d = result_q;
        ld_en    = 1'b0;
        wb_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ld_en = load;
                if (start) begin
                    // Source is read from the pre-load register state.
                    acc_d   = (op_e'(op) == OpCompl) ? ~regs_q[rd_sel] : regs_q[rd_sel];
                    op_d    = op;
                    dst_d   = dst_sel;
                    cnt_d   = is_shift_op(op_e'(op)) ? sh : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    acc_d = step_out;
                    cnt_d = cnt_q - CntOne;
                end else begin
                    result_d = acc_q;
                    wb_en    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            result_q <= result_d;
        end
    end

    // Load and writeback are never active together: load only in IDLE,
    // writeback only in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs_q[wr_sel] <= fb ? result_q : in;
            end
            if (wb_en) begin
                regs_q[dst_q] <= acc_q;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign rd_data = regs_q[rd_sel];

endmodule

// File: tb/tb_shift_proc_unit.sv
// Directed bench for shift_proc_unit (WIDTH=8, NREG=4) with hand-computed
// expected values.
module tb_shift_proc_unit;

    logic       clk;
    logic       reset;
    logic       load;
    logic       fb;
    logic [7:0] in;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic [1:0] dst_sel;
    logic [2:0] op;
    logic [2:0] sh;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] rd_data;

    int n_vec;
    int n_bad;

    shift_proc_unit #(
        .WIDTH (8),
        .NREG  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .fb      (fb),
        .in      (in),
        .wr_sel  (wr_sel),
        .rd_sel  (rd_sel),
        .dst_sel (dst_sel),
        .op      (op),
        .sh      (sh),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string tag);
        rd_sel = sel;
        #1;
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic load_reg(input logic [1:0] sel, input logic [7:0] val, input logic use_fb);
        load   = 1'b1;
        fb     = use_fb;
        wr_sel = sel;
        in     = val;
        tick();
        load = 1'b0;
        fb   = 1'b0;
    endtask

    // Wait for done starting from cycle 'first'; returns the cycle it was seen.
    task automatic wait_done(input int first, output int cyc);
        cyc = first;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input logic [1:0] rd, input logic [1:0] dst, input logic [2:0] opc,
                          input logic [2:0] amt, input logic [7:0] exp_res, input int exp_cyc,
                          input string tag);
        int cyc;
        rd_sel  = rd;
        dst_sel = dst;
        op      = opc;
        sh      = amt;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(1, cyc);
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        tick();
        check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        load    = 1'b0;
        fb      = 1'b0;
        in      = 8'h00;
        wr_sel  = 2'd0;
        rd_sel  = 2'd0;
        dst_sel = 2'd0;
        op      = 3'd0;
        sh      = 3'd0;
        start   = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {24'd0, result}, 32'd0);
        for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, "reset reg");

        load_reg(2'd1, 8'h96, 1'b0);
        peek(2'd1, 8'h96, "load reg1");

        run_op(2'd1, 2'd2, 3'b011, 3'd3, 8'hB0, 5, "lsl3");
        peek(2'd2, 8'hB0, "lsl3 reg2");
        peek(2'd1, 8'h96, "lsl3 reg1 kept");

        load_reg(2'd3, 8'h00, 1'b1);
        peek(2'd3, 8'hB0, "fb reg3");

        run_op(2'd1, 2'd0, 3'b100, 3'd1, 8'h4B, 3, "ror1");
        run_op(2'd1, 2'd0, 3'b110, 3'd2, 8'hE5, 4, "asr2");
        run_op(2'd1, 2'd0, 3'b010, 3'd7, 8'h01, 9, "lsr7");
        run_op(2'd1, 2'd0, 3'b101, 3'd3, 8'hB4, 5, "rol3");
        run_op(2'd1, 2'd0, 3'b001, 3'd5, 8'h69, 2, "compl");
        run_op(2'd1, 2'd0, 3'b000, 3'd5, 8'h96, 2, "pass");
        run_op(2'd1, 2'd0, 3'b111, 3'd5, 8'h96, 2, "op7");
        peek(2'd0, 8'h96, "op7 reg0");

        // start/load while busy must be dropped
        rd_sel  = 2'd1;
        dst_sel = 2'd0;
        op      = 3'b011;
        sh      = 3'd3;
        start   = 1'b1;
        tick();
        rd_sel  = 2'd2;
        dst_sel = 2'd3;
        op      = 3'b001;
        sh      = 3'd0;
        load    = 1'b1;
        wr_sel  = 2'd1;
        in      = 8'h55;
        tick();
        start = 1'b0;
        load  = 1'b0;
        wait_done(2, cyc);
        check("busy-ignore latency", cyc, 5);
        check("busy-ignore result", {24'd0, result}, 32'hB0);
        tick();
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            tick();
        end
        check("busy-ignore extra done", dones, 0);
        peek(2'd0, 8'hB0, "busy-ignore reg0");
        peek(2'd1, 8'h96, "busy-ignore reg1");
        peek(2'd2, 8'hB0, "busy-ignore reg2");
        peek(2'd3, 8'hB0, "busy-ignore reg3");

        // start and load together in IDLE: start sees the old value
        load   = 1'b1;
        wr_sel = 2'd1;
        in     = 8'h3C;
        run_op(2'd1, 2'd0, 3'b000, 3'd0, 8'h96, 2, "start+load");
        load = 1'b0;
        peek(2'd1, 8'h3C, "start+load reg1");

        run_op(2'd1, 2'd1, 3'b011, 3'd1, 8'h78, 3, "src=dst");
        peek(2'd1, 8'h78, "src=dst reg1");

        // reset in cycle 2 of an sh=3 run
        rd_sel  = 2'd1;
        dst_sel = 2'd2;
        op      = 3'b011;
        sh      = 3'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", {24'd0, result}, 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort no done", dones, 0);
        for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, "abort reg");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
